frame_tx_scheduler: RTL and testbench
=====================================

# frame_tx_scheduler

Transmit scheduler between the user frame-entry logic and the four EndDevice transmitters of the L2 switch simulator. It buffers up to DEPTH pre-built 16-bit frames in a FIFO, each tagged with its source port. On a send command it releases the frames one at a time, in arrival order, to the owning EndDevice. Consecutive releases are spaced by a fixed gap so that serialization and switch forwarding of one frame finish before the next starts. This replaces the "fire all pending frames in one cycle" behaviour and prevents same-port overwrites and switch FIFO collisions.

## Interface
Parameters:
- DEPTH, 4, FIFO slots (power of two, ≥2)
- FRAME_W, 16, frame width ({SFD, DST, SRC, PAYLOAD})
- NUM_PORTS, 4, number of EndDevice ports
- TX_GAP, 24, cycles between consecutive tx_valid pulses (≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- add_valid  in  1  push request, single-cycle pulse
- add_frame  in  FRAME_W  frame to queue
- add_src  in  2  source port index (0=A..3=D)
- add_ready  out  1  high when count != DEPTH
- drop  out  1  one-cycle pulse: push rejected because FIFO full
- send_start  in  1  pulse: begin draining the FIFO
- flush  in  1  pulse: discard all queued frames, abort drain
- tx_frame  out  FRAME_W  frame for the port flagged in tx_valid
- tx_valid  out  NUM_PORTS  one-hot, one-cycle strobe to EndDevice[src]
- busy  out  1  high while state != IDLE
- pending_count  out  log2(DEPTH)+1  frames currently queued

## Operation
- Storage: circular FIFO of {add_src, add_frame}; wr_ptr, rd_ptr (log2(DEPTH) bits, natural wrap), count (0..DEPTH).
- Push: if add_valid && count != DEPTH (registered count), write at wr_ptr and increment wr_ptr.
- Push rejected: if add_valid && count == DEPTH, no write, drop=1 next cycle. A push is rejected even if a pop happens in the same cycle.
- Push and pop in the same cycle: both take effect and count is unchanged.
- State machine, two states, IDLE and GAP:
  - IDLE: if send_start && count>0, issue. If send_start && count==0, ignore and stay IDLE.
  - Issue, at one clock edge: tx_frame<=head frame; tx_valid<=1<<head src; rd_ptr++; gap_cnt<=TX_GAP-1; state<=GAP.
  - GAP: tx_valid<=0. If gap_cnt!=0, decrement it. If gap_cnt==0 and count>0, issue. If gap_cnt==0 and count==0, go to IDLE.
  - send_start in GAP is ignored. Frames pushed during a drain are sent in the same drain.
- flush has priority over add_valid and send_start. It clears wr_ptr, rd_ptr and count, sets state to IDLE, and forces tx_valid=0 at the next edge. A push in the same cycle as flush is discarded and drop stays 0.
- tx_frame holds its last issued value between strobes. Only tx_valid qualifies it.

## Timing
- Reset values: tx_valid=0, tx_frame=0, drop=0, busy=0, pending_count=0, add_ready=1, state IDLE, all pointers and counters 0.
- Send latency: send_start sampled at edge N gives tx_valid high for the single cycle after edge N.
- Spacing: consecutive tx_valid pulses are exactly TX_GAP cycles apart.
- busy falls TX_GAP cycles after the last tx_valid pulse, measured from that pulse's rising edge.
- pending_count and add_ready update one cycle after a push, pop or flush edge.
- Reset asserted mid-drain: outputs go to their reset values immediately (asynchronous). Queued frames are lost and no further strobes follow.
- At most one tx_valid bit is ever high.

## Test plan
- Push 0x5AB7 (src 1), 0x5CA3 (src 2), 0x5DB9 (src 3), then pulse send_start.
  - Required: tx_valid=4'b0010 / tx_frame=0x5AB7 one cycle later.
  - Then 4'b0100 / 0x5CA3 at +24 cycles and 4'b1000 / 0x5DB9 at +48.
  - busy drops 24 cycles after the last strobe; pending_count=0.
- Push 4 frames, then a 5th.
  - Required: add_ready=0, drop pulses once, pending_count stays 4.
  - On drain, exactly 4 strobes carrying the first 4 frames in order.
- send_start with an empty FIFO.
  - Required: busy stays 0 and no tx_valid for 100 cycles.
- Drain wrap-around: push 3 and drain; push 4 (pointers wrap) and drain.
  - Required: all 7 frames appear in FIFO order with the correct one-hot port.
- Simultaneous events: push during the cycle of an issue.
  - Required: pending_count unchanged that cycle, and the new frame is sent in the same drain.
- Flush and reset mid-drain: flush after the first strobe of a 3-frame drain.
  - Required: no further tx_valid, busy=0 and pending_count=0 next cycle.
  - Repeat with rst instead: outputs reach reset values immediately.

Source files
------------

// File: rtl/frame_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_scheduler_if
// Description : Bundle of frame-entry, command and EndDevice strobe signals
//               between the user logic (master) and the transmit scheduler
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_tx_scheduler_if #(
  parameter int FRAME_W   = 16,
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 add_valid;
  logic [FRAME_W-1:0]   add_frame;
  logic [1:0]           add_src;
  logic                 add_ready;
  logic                 drop;
  logic                 send_start;
  logic                 flush;
  logic [FRAME_W-1:0]   tx_frame;
  logic [NUM_PORTS-1:0] tx_valid;
  logic                 busy;
  logic [CNT_W-1:0]     pending_count;

  // User side: queues frames and issues commands, observes the strobes.
  modport master (
    output add_valid, add_frame, add_src, send_start, flush,
    input  add_ready, drop, tx_frame, tx_valid, busy, pending_count
  );

  // Scheduler side.
  modport slave (
    input  add_valid, add_frame, add_src, send_start, flush,
    output add_ready, drop, tx_frame, tx_valid, busy, pending_count
  );
endinterface
`default_nettype wire

// File: rtl/frame_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_tx_scheduler
// Description : Buffers source-tagged frames in a small circular FIFO and,
//               on send_start, releases them one per TX_GAP cycles to the
//               owning EndDevice as a one-hot tx_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_scheduler #(
  parameter int DEPTH     = 4,
  parameter int FRAME_W   = 16,
  parameter int NUM_PORTS = 4,
  parameter int TX_GAP    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_tx_scheduler_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(TX_GAP);
  localparam int ENT_W = 2 + FRAME_W;

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(TX_GAP - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  state_t               state_q,    state_d;
  logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]     count_q,    count_d;
  logic [GAP_W-1:0]     gap_cnt_q,  gap_cnt_d;
  logic [FRAME_W-1:0]   tx_frame_q, tx_frame_d;
  logic [NUM_PORTS-1:0] tx_valid_q, tx_valid_d;
  logic                 drop_q,     drop_d;

  logic [ENT_W-1:0]     mem_q [DEPTH];

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [1:0]           head_src;
  logic [FRAME_W-1:0]   head_frame;
  logic [NUM_PORTS-1:0] head_onehot;

  assign {head_src, head_frame} = mem_q[rd_ptr_q];

  // One-hot port select decoded from the head entry's source tag.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port_sel
      assign head_onehot[gi] = (head_src == 2'(gi));
    end
  endgenerate

  // FIFO status and push acceptance; fullness uses the registered count, so
  // a pop in the same cycle does not make room for a push.
  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    fifo_empty = (count_q == '0);
    push       = bus.add_valid && !bus.flush && !fifo_full;
    drop_d     = bus.add_valid && !bus.flush && fifo_full;
  end

  // Release scheduler: decides when to issue the head frame and spaces issues.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    tx_valid_d = '0;
    tx_frame_d = tx_frame_q;
    pop        = 1'b0;

    if (bus.flush) begin
      state_d   = S_IDLE;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.send_start && !fifo_empty) begin
            pop = 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (pop) begin
      tx_frame_d = head_frame;
      tx_valid_d = head_onehot;
      gap_cnt_d  = GAP_RELOAD;
      state_d    = S_GAP;
    end
  end

  // Pointer and occupancy update; flush empties the queue outright.
  always_comb begin
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_cnt_q  <= '0;
      tx_frame_q <= '0;
      tx_valid_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_frame_q <= tx_frame_d;
      tx_valid_q <= tx_valid_d;
      drop_q     <= drop_d;
    end
  end

  // Frame storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.add_src, bus.add_frame};
    end
  end

  assign bus.tx_frame      = tx_frame_q;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.drop          = drop_q;
  assign bus.busy          = (state_q == S_GAP);
  assign bus.pending_count = count_q;
  assign bus.add_ready     = !fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_tx_scheduler
// Description : Scoreboard bench for frame_tx_scheduler. A queue-based model
//               predicts each strobe's edge, port and frame; a negedge
//               monitor pops and compares, and also tracks status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_tx_scheduler;

  localparam int DEPTH     = 4;
  localparam int FRAME_W   = 16;
  localparam int NUM_PORTS = 4;
  localparam int TX_GAP    = 24;
  localparam int PERIOD    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #(PERIOD/2) clk = ~clk;

  frame_tx_scheduler_if #(
    .FRAME_W(FRAME_W), .NUM_PORTS(NUM_PORTS), .DEPTH(DEPTH)
  ) bus ();

  frame_tx_scheduler #(
    .DEPTH(DEPTH), .FRAME_W(FRAME_W), .NUM_PORTS(NUM_PORTS), .TX_GAP(TX_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    longint     cyc;
    logic [1:0] src;
    logic [15:0] frame;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [17:0] m_fifo[$];
  bit          m_active = 1'b0;
  longint      m_next   = 0;
  bit          m_drop   = 1'b0;

  // Edge index: posedges at 5,15,25... map to 1,2,3; the following negedge
  // maps to the same index.
  function automatic longint now_edge();
    return (longint'($time) + PERIOD/2) / PERIOD;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, now_edge());
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_valid"}, longint'(bus.tx_valid), 0);
    check({tag, "_tx_frame"}, longint'(bus.tx_frame), 0);
    check({tag, "_drop"}, longint'(bus.drop), 0);
    check({tag, "_busy"}, longint'(bus.busy), 0);
    check({tag, "_pending"}, longint'(bus.pending_count), 0);
    check({tag, "_add_ready"}, longint'(bus.add_ready), 1);
  endtask

  // Reference model: an arrival-ordered queue plus the time of the next
  // allowed release. Each release is logged to the scoreboard with its edge.
  always @(posedge clk or posedge rst) begin : model
    longint     e;
    int         cnt;
    bit         issue;
    logic [17:0] ent;
    if (rst) begin
      m_fifo.delete();
      sb.delete();
      m_active = 1'b0;
      m_drop   = 1'b0;
    end else begin
      e      = now_edge();
      cnt    = m_fifo.size();
      issue  = 1'b0;
      m_drop = 1'b0;
      if (bus.flush) begin
        m_fifo.delete();
        m_active = 1'b0;
      end else begin
        if (m_active) begin
          if (e >= m_next) begin
            if (cnt > 0) issue = 1'b1;
            else         m_active = 1'b0;
          end
        end else if (bus.send_start && cnt > 0) begin
          issue = 1'b1;
        end
        if (issue) begin
          ent = m_fifo.pop_front();
          sb.push_back('{e, ent[17:16], ent[15:0]});
          m_active = 1'b1;
          m_next   = e + TX_GAP;
        end
        if (bus.add_valid) begin
          if (cnt < DEPTH) m_fifo.push_back({bus.add_src, bus.add_frame});
          else             m_drop = 1'b1;
        end
      end
    end
  end

  // Monitor: compares strobes against the scoreboard and status every cycle.
  always @(negedge clk) begin : monitor
    longint e;
    exp_t   x;
    if (!rst) begin
      e = now_edge();
      if (bus.tx_valid != '0) begin
        check("tx_valid_onehot", longint'($onehot(bus.tx_valid)), 1);
        if (sb.size() == 0) begin
          check("unexpected_strobe", longint'(bus.tx_valid), 0);
        end else begin
          x = sb.pop_front();
          check("strobe_edge", e, x.cyc);
          check("tx_valid_port", longint'(bus.tx_valid), longint'(1) << x.src);
          check("tx_frame", longint'(bus.tx_frame), longint'(x.frame));
        end
      end
      while (sb.size() > 0 && sb[0].cyc < e) begin
        check("missed_strobe_edge", e, sb[0].cyc);
        void'(sb.pop_front());
      end
      check("busy", longint'(bus.busy), longint'(m_active));
      check("pending_count", longint'(bus.pending_count), longint'(m_fifo.size()));
      check("add_ready", longint'(bus.add_ready), longint'(m_fifo.size() != DEPTH));
      check("drop", longint'(bus.drop), longint'(m_drop));
    end
  end

  // Inputs change 2 time units after a posedge and are sampled at the next.
  task automatic drive(input bit av, input logic [15:0] f, input logic [1:0] s,
                       input bit ss, input bit fl);
    bus.add_valid  = av;
    bus.add_frame  = f;
    bus.add_src    = s;
    bus.send_start = ss;
    bus.flush      = fl;
    @(posedge clk); #2;
    bus.add_valid  = 1'b0;
    bus.send_start = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic push(input logic [15:0] f, input logic [1:0] s);
    drive(1'b1, f, s, 1'b0, 1'b0);
  endtask

  task automatic send();
    drive(1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (m_active && k < 2000) begin
      idle(1);
      k++;
    end
    check("drain_timeout", longint'(m_active), 0);
    idle(2);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    bus.add_valid  = 1'b0;
    bus.add_frame  = '0;
    bus.add_src    = '0;
    bus.send_start = 1'b0;
    bus.flush      = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    check_reset_vals("reset");
    idle(2);
    rst = 1'b0;
    idle(2);

    // Three frames to ports B, C, D; first strobe one cycle after send_start.
    push(16'h5AB7, 2'd1);
    push(16'h5CA3, 2'd2);
    push(16'h5DB9, 2'd3);
    send();
    check("t1_first_port", longint'(bus.tx_valid), 4'b0010);
    check("t1_first_frame", longint'(bus.tx_frame), 16'h5AB7);
    wait_drain();
    check("t1_pending_after", longint'(bus.pending_count), 0);

    // Overfill: fifth push is dropped, queue stays at four.
    for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i), 2'(i));
    check("t2_add_ready_full", longint'(bus.add_ready), 0);
    push(16'hBEEF, 2'd0);
    check("t2_drop_pulse", longint'(bus.drop), 1);
    check("t2_pending_full", longint'(bus.pending_count), 4);
    send();
    wait_drain();

    // send_start on an empty queue does nothing.
    send();
    idle(100);
    check("t3_busy_empty", longint'(bus.busy), 0);

    // Wrap-around: three then four frames.
    for (int i = 0; i < 3; i++) push(16'(($urandom)), 2'($urandom_range(0, 3)));
    send();
    wait_drain();
    for (int i = 0; i < 4; i++) push(16'(($urandom)), 2'($urandom_range(0, 3)));
    send();
    wait_drain();

    // Push sampled on the same edge as the second issue.
    push(16'h1111, 2'd0);
    push(16'h2222, 2'd1);
    send();
    idle(TX_GAP - 1);
    push(16'h3333, 2'd2);
    wait_drain();

    // Flush after the first strobe of a three-frame drain.
    push(16'h4441, 2'd3);
    push(16'h4442, 2'd2);
    push(16'h4443, 2'd1);
    send();
    idle(3);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 1'b1);
    check("t6_busy_after_flush", longint'(bus.busy), 0);
    check("t6_pending_after_flush", longint'(bus.pending_count), 0);
    idle(60);

    // Reset while a strobe is high: outputs clear without a clock edge.
    push(16'h6661, 2'd0);
    push(16'h6662, 2'd1);
    push(16'h6663, 2'd2);
    send();
    check("t7_strobe_before_rst", longint'(bus.tx_valid), 4'b0001);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid_drain");
    idle(2);
    rst = 1'b0;
    idle(60);

    // Randomized traffic including full-queue pushes, sends and flushes.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 3) == 0, 16'($urandom), 2'($urandom_range(0, 3)),
            ($urandom % 12) == 0, ($urandom % 80) == 0);
    end
    wait_drain();
    check("scoreboard_empty", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
